sprite_motion_mc: RTL and testbench
===================================

# sprite_motion_mc

Multi-channel successor to the single-sprite position engine: keeps N_SPR independent sprites, each with horizontal run, jump and gravity physics, floor tracking and optional block collision. One update sweep runs per frame pulse, processing one channel per clock. It sits between the control decoders and the sprite renderers, feeding per-channel screen coordinates and animation flags.

## Interface
- N_SPR, 4: sprite channel count (1-16)
- CORDW, 16: signed coordinate width
- SPD_W, 8: unsigned run-speed and jump-velocity width
- VEL_W, 8: signed vertical-velocity width
- SPR_W, 19 / SPR_H, 27: sprite size in pixels
- H_RES, 800 / V_RES, 600: screen size
- X0, 16 / X_STEP, 64: reset x of channel k is X0 + k*X_STEP
- Y0, 0: reset y of all channels
- GRAVITY, 1: vy increment per frame while airborne
- VMAX, 12: vy saturation limit (positive = downward)
- i_clk_pix  in  1  pixel clock
- i_rst_n  in  1  asynchronous active-low reset
- i_frame  in  1  frame-start pulse
- i_left, i_right, i_jump  in  N_SPR  per-channel controls
- i_run_speed  in  SPD_W  shared horizontal step per frame
- i_jump_vel  in  SPD_W  shared initial upward speed
- i_floor  in  CORDW  signed floor height above screen bottom
- i_blk_left, i_blk_right, i_blk_height  in  CORDW  obstacle block extent
- o_sprx, o_spry  out  N_SPR*CORDW  signed positions, channel k at [k*CORDW +: CORDW]
- o_face_left, o_walking, o_jumping  out  N_SPR  per-channel flags
- o_busy  out  1  sweep in progress
- o_done  out  1  one-cycle sweep-complete pulse
- o_overrun  out  1  sticky: i_frame arrived while busy

## Operation
- FSM: IDLE -> (i_frame) UPDATE -> (idx == N_SPR-1) DONE -> IDLE. In UPDATE, channel idx is updated, then idx increments.
- Reset values: sprx = X0+k*X_STEP, spry = Y0, vy = 0, air = 1 (o_jumping all ones), o_face_left = 0, o_walking = 0, o_busy = o_done = o_overrun = 0, state IDLE.
- Horizontal:
  - right&!left: dx = +speed, face = 0.
  - left&!right: dx = -speed, face = 1.
  - Otherwise dx = 0 and face is held.
  - o_walking = (dx != 0).
  - x_new is clamped to [0, H_RES-SPR_W].
- Ground level: G = V_RES - i_floor - SPR_H. With collision on, if x_new overlaps [blk_left, blk_right), G = min(G, V_RES - blk_height - SPR_H).
- Vertical, grounded (air = 0):
  - jump: vy = -i_jump_vel, air = 1, y held this frame.
  - Otherwise, if y < G (walked off a ledge or floor dropped): air = 1, vy = 0.
  - Otherwise y = G.
- Vertical, airborne:
  - y_new = y + vy, then vy = min(vy + GRAVITY, VMAX).
  - If y_new >= G: y = G, vy = 0, air = 0. Landing wins over a simultaneous jump; the jump is taken next frame if still held.
- o_jumping = air.
- Arithmetic: all position math is sign-extended to CORDW+2 bits before clamping; speeds are zero-extended.

## Timing
- i_frame is sampled only in IDLE. Edge E0 enters UPDATE with o_busy = 1.
- Edge Ek (k = 1..N_SPR) registers channel k-1 outputs; other channels hold.
- DONE state occupies the cycle after E_N_SPR with o_done = 1. E_N_SPR+1 returns to IDLE with o_busy = 0. Total latency is N_SPR+1 cycles.
- Inputs are sampled at each channel's write edge. Sources must hold them stable for the whole sweep.
- i_frame in UPDATE or DONE is ignored and sets o_overrun. Only reset clears o_overrun.
- Asynchronous reset mid-sweep aborts immediately. All state returns to reset values and no partial update survives.

## Configuration
- SPRITE_MOTION_COLLIDE_EN defined: block collision is active.
  - Moving right with y+SPR_H > V_RES-blk_height, x+SPR_W <= blk_left and x_new+SPR_W > blk_left: x_new = blk_left-SPR_W.
  - Moving left with the same vertical overlap, x >= blk_right and x_new < blk_right: x_new = blk_right.
  - Block top counts as ground.
- Undefined: the i_blk_* inputs are unused, only floor and screen-edge clamps apply, and RTL size shrinks.

## Test plan
- Reset with N_SPR = 4: sprx = 16/80/144/208, spry = 0, o_jumping = 4'b1111, o_busy = 0. After i_frame: o_busy for 5 cycles, o_done on cycle 5.
- Fall with i_floor = 40 (G = 533), GRAVITY = 1, VMAX = 12: y after frames 1-5 = 0, 1, 3, 6, 10. Channels land exactly at 533 and o_jumping clears.
- Grounded channel 1 with i_right, speed 3: x += 3 per frame, o_walking[1] = 1. Left+right together: x held, walking = 0, face held. Run into the right edge: x clamps to 781.
- Jump with i_jump_vel = 10 on a grounded channel: jump frame holds y. Then deltas -10, -9, ..., +10 over 21 frames, landing at G with o_jumping = 0.
- i_frame pulsed at cycle 2 of a sweep: sweep unaffected, o_overrun = 1 until reset. Reset asserted at cycle 3: all outputs return to reset values that cycle.
- COLLIDE_EN with blk_left = 300, blk_height = 100, grounded at x = 275, speed 8 right: x stops at 281. Jump over the block: lands at y = 473.

Source files
------------

// File: rtl/sprite_motion_mc.sv
// Multi-channel sprite position engine: one channel per clock per frame sweep.
// Optional block collision is enabled by defining SPRITE_MOTION_COLLIDE_EN.
module sprite_motion_mc #(
  parameter int N_SPR   = 4,
  parameter int CORDW   = 16,
  parameter int SPD_W   = 8,
  parameter int VEL_W   = 8,
  parameter int SPR_W   = 19,
  parameter int SPR_H   = 27,
  parameter int H_RES   = 800,
  parameter int V_RES   = 600,
  parameter int X0      = 16,
  parameter int X_STEP  = 64,
  parameter int Y0      = 0,
  parameter int GRAVITY = 1,
  parameter int VMAX    = 12
) (
  input  logic                   i_clk_pix,
  input  logic                   i_rst_n,
  input  logic                   i_frame,
  input  logic [N_SPR-1:0]       i_left,
  input  logic [N_SPR-1:0]       i_right,
  input  logic [N_SPR-1:0]       i_jump,
  input  logic [SPD_W-1:0]       i_run_speed,
  input  logic [SPD_W-1:0]       i_jump_vel,
  input  logic [CORDW-1:0]       i_floor,
  input  logic [CORDW-1:0]       i_blk_left,
  input  logic [CORDW-1:0]       i_blk_right,
  input  logic [CORDW-1:0]       i_blk_height,
  output logic [N_SPR*CORDW-1:0] o_sprx,
  output logic [N_SPR*CORDW-1:0] o_spry,
  output logic [N_SPR-1:0]       o_face_left,
  output logic [N_SPR-1:0]       o_walking,
  output logic [N_SPR-1:0]       o_jumping,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_overrun
);
  localparam int W     = CORDW + 2;
  localparam int VW    = VEL_W + 2;
  localparam int IDX_W = (N_SPR > 1) ? $clog2(N_SPR) : 1;
  localparam logic [IDX_W-1:0]    LAST = IDX_W'(N_SPR - 1);
  localparam logic signed [W-1:0] XMAX = W'(H_RES - SPR_W);
  localparam logic signed [W-1:0] SW   = W'(SPR_W);
  localparam logic signed [W-1:0] SH   = W'(SPR_H);
  localparam logic signed [W-1:0] VRES = W'(V_RES);
  localparam logic signed [VW-1:0] GRAV = VW'(GRAVITY);
  localparam logic signed [VW-1:0] VLIM = VW'(VMAX);

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_t;
  state_t state, state_nxt;

  logic [IDX_W-1:0]        idx;
  logic signed [CORDW-1:0] sprx_q [N_SPR];
  logic signed [CORDW-1:0] spry_q [N_SPR];
  logic signed [VEL_W-1:0] vy_q   [N_SPR];
  logic [N_SPR-1:0]        air_q, face_q, walk_q;

  logic signed [W-1:0]  x_cur, y_cur, spd, dx, x_raw, x_nxt, g_lvl, y_fall, y_nxt;
  logic signed [VW-1:0] vy_cur, vy_inc, vy_nxt;
  logic                 face_nxt, air_nxt;
  logic                 unused_bits;

  always_ff @(posedge i_clk_pix or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (i_frame) state_nxt = S_UPDATE;
      S_UPDATE: if (idx == LAST) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state != S_IDLE);
    o_done = (state == S_DONE);
  end

  // Next state of the channel currently addressed by idx.
  always_comb begin
    x_cur    = W'(sprx_q[idx]);
    y_cur    = W'(spry_q[idx]);
    vy_cur   = VW'(vy_q[idx]);
    spd      = W'(i_run_speed);
    dx       = '0;
    face_nxt = face_q[idx];
    if (i_right[idx] && !i_left[idx]) begin
      dx       = spd;
      face_nxt = 1'b0;
    end else if (i_left[idx] && !i_right[idx]) begin
      dx       = -spd;
      face_nxt = 1'b1;
    end
    x_raw = x_cur + dx;
`ifdef SPRITE_MOTION_COLLIDE_EN
    begin
      logic signed [W-1:0] bl, br, blk_top;
      logic                v_ov;
      bl      = W'($signed(i_blk_left));
      br      = W'($signed(i_blk_right));
      blk_top = VRES - W'($signed(i_blk_height));
      v_ov    = (y_cur + SH) > blk_top;
      if (!dx[W-1] && dx != '0 && v_ov && (x_cur + SW) <= bl && (x_raw + SW) > bl)
        x_raw = bl - SW;
      if (dx[W-1] && v_ov && x_cur >= br && x_raw < br)
        x_raw = br;
`endif
      if (x_raw[W-1])        x_nxt = '0;
      else if (x_raw > XMAX) x_nxt = XMAX;
      else                   x_nxt = x_raw;
      g_lvl = VRES - SH - W'($signed(i_floor));
`ifdef SPRITE_MOTION_COLLIDE_EN
      // Standing on the block only needs any horizontal overlap with its span.
      if (x_nxt < br && (x_nxt + SW) > bl && (blk_top - SH) < g_lvl)
        g_lvl = blk_top - SH;
    end
`endif

    y_fall = y_cur + W'(vy_cur);
    vy_inc = vy_cur + GRAV;
    if (vy_inc > VLIM) vy_inc = VLIM;
    y_nxt   = y_cur;
    vy_nxt  = vy_cur;
    air_nxt = air_q[idx];
    if (!air_q[idx]) begin
      if (i_jump[idx]) begin
        vy_nxt  = -VW'(i_jump_vel);
        air_nxt = 1'b1;
      end else if (y_cur < g_lvl) begin
        vy_nxt  = '0;
        air_nxt = 1'b1;
      end else begin
        y_nxt = g_lvl;
      end
    end else if (y_fall >= g_lvl) begin
      y_nxt   = g_lvl;
      vy_nxt  = '0;
      air_nxt = 1'b0;
    end else begin
      y_nxt  = y_fall;
      vy_nxt = vy_inc;
    end
  end

  always_ff @(posedge i_clk_pix or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx       <= '0;
      o_overrun <= 1'b0;
      air_q     <= '1;
      face_q    <= '0;
      walk_q    <= '0;
      for (int unsigned k = 0; k < N_SPR; k++) begin
        sprx_q[k] <= CORDW'(X0 + int'(k) * X_STEP);
        spry_q[k] <= CORDW'(Y0);
        vy_q[k]   <= '0;
      end
    end else begin
      if (i_frame && state != S_IDLE) o_overrun <= 1'b1;
      if (state == S_UPDATE) begin
        idx         <= (idx == LAST) ? '0 : idx + 1'b1;
        sprx_q[idx] <= x_nxt[CORDW-1:0];
        spry_q[idx] <= y_nxt[CORDW-1:0];
        vy_q[idx]   <= vy_nxt[VEL_W-1:0];
        air_q[idx]  <= air_nxt;
        face_q[idx] <= face_nxt;
        walk_q[idx] <= (dx != '0);
      end
    end
  end

  always_comb begin
    o_sprx = '0;
    o_spry = '0;
    for (int unsigned k = 0; k < N_SPR; k++) begin
      o_sprx[k*CORDW +: CORDW] = sprx_q[k];
      o_spry[k*CORDW +: CORDW] = spry_q[k];
    end
    o_face_left = face_q;
    o_walking   = walk_q;
    o_jumping   = air_q;
  end

`ifdef SPRITE_MOTION_COLLIDE_EN
  assign unused_bits = ^{x_nxt[W-1:CORDW], y_nxt[W-1:CORDW], vy_nxt[VW-1:VEL_W]};
`else
  assign unused_bits = ^{x_nxt[W-1:CORDW], y_nxt[W-1:CORDW], vy_nxt[VW-1:VEL_W],
                         i_blk_left, i_blk_right, i_blk_height};
`endif

endmodule

// File: tb/tb_sprite_motion_mc.sv
// Directed + randomized bench for sprite_motion_mc with an arithmetic reference model.
module tb_sprite_motion_mc;
  localparam int N  = 4;
  localparam int CW = 16;

  logic            i_clk_pix = 1'b0;
  logic            i_rst_n   = 1'b0;
  logic            i_frame   = 1'b0;
  logic [N-1:0]    i_left = '0, i_right = '0, i_jump = '0;
  logic [7:0]      i_run_speed = '0, i_jump_vel = '0;
  logic [CW-1:0]   i_floor = '0, i_blk_left = '0, i_blk_right = '0, i_blk_height = '0;
  logic [N*CW-1:0] o_sprx, o_spry;
  logic [N-1:0]    o_face_left, o_walking, o_jumping;
  logic            o_busy, o_done, o_overrun;

  sprite_motion_mc #(.N_SPR(N), .CORDW(CW)) dut (
    .i_clk_pix(i_clk_pix), .i_rst_n(i_rst_n), .i_frame(i_frame),
    .i_left(i_left), .i_right(i_right), .i_jump(i_jump),
    .i_run_speed(i_run_speed), .i_jump_vel(i_jump_vel), .i_floor(i_floor),
    .i_blk_left(i_blk_left), .i_blk_right(i_blk_right), .i_blk_height(i_blk_height),
    .o_sprx(o_sprx), .o_spry(o_spry), .o_face_left(o_face_left),
    .o_walking(o_walking), .o_jumping(o_jumping),
    .o_busy(o_busy), .o_done(o_done), .o_overrun(o_overrun)
  );

  always #5 i_clk_pix = ~i_clk_pix;

  int n_vec = 0;
  int n_err = 0;
  int mx[N], my[N], mvy[N];
  bit mair[N], mface[N], mwalk[N];
  bit m_ovr;

  task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      mx[k] = 16 + 64 * k; my[k] = 0; mvy[k] = 0;
      mair[k] = 1; mface[k] = 0; mwalk[k] = 0;
    end
    m_ovr = 0;
  endfunction

  // One frame of physics for every channel, straight from the motion rules.
  function automatic void model_frame();
    int dx, xn, g, yn, fl, bl, br, bh;
    fl = int'($signed(i_floor));
    bl = int'($signed(i_blk_left));
    br = int'($signed(i_blk_right));
    bh = int'($signed(i_blk_height));
    for (int k = 0; k < N; k++) begin
      dx = 0;
      if (i_right[k] && !i_left[k]) begin dx = i_run_speed; mface[k] = 0; end
      else if (i_left[k] && !i_right[k]) begin dx = -int'(i_run_speed); mface[k] = 1; end
      mwalk[k] = (dx != 0);
      xn = mx[k] + dx;
`ifdef SPRITE_MOTION_COLLIDE_EN
      if (dx > 0 && my[k] + 27 > 600 - bh && mx[k] + 19 <= bl && xn + 19 > bl) xn = bl - 19;
      if (dx < 0 && my[k] + 27 > 600 - bh && mx[k] >= br && xn < br) xn = br;
`endif
      if (xn < 0) xn = 0;
      if (xn > 781) xn = 781;
      g = 600 - fl - 27;
`ifdef SPRITE_MOTION_COLLIDE_EN
      if (xn < br && xn + 19 > bl && 600 - bh - 27 < g) g = 600 - bh - 27;
`endif
      if (!mair[k]) begin
        if (i_jump[k]) begin mvy[k] = -int'(i_jump_vel); mair[k] = 1; end
        else if (my[k] < g) begin mvy[k] = 0; mair[k] = 1; end
        else my[k] = g;
      end else begin
        yn = my[k] + mvy[k];
        mvy[k] = (mvy[k] + 1 > 12) ? 12 : mvy[k] + 1;
        if (yn >= g) begin my[k] = g; mvy[k] = 0; mair[k] = 0; end
        else my[k] = yn;
      end
      mx[k] = xn;
    end
  endfunction

  task automatic check_all(input string tag);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s sprx[%0d]", tag, k), $signed(o_sprx[k*CW +: CW]), mx[k]);
      chk($sformatf("%s spry[%0d]", tag, k), $signed(o_spry[k*CW +: CW]), my[k]);
      chk($sformatf("%s face[%0d]", tag, k), o_face_left[k], int'(mface[k]));
      chk($sformatf("%s walk[%0d]", tag, k), o_walking[k], int'(mwalk[k]));
      chk($sformatf("%s jump[%0d]", tag, k), o_jumping[k], int'(mair[k]));
    end
    chk({tag, " overrun"}, o_overrun, int'(m_ovr));
  endtask

  // Entered and left at posedge+1 in IDLE; sweep has a fixed length so no wait can hang.
  task automatic run_frame(input string tag);
    i_frame = 1'b1;
    @(posedge i_clk_pix); #1;
    i_frame = 1'b0;
    chk({tag, " busy@E0"}, o_busy, 1);
    for (int c = 1; c <= N; c++) begin
      @(posedge i_clk_pix); #1;
      chk({tag, " done"}, o_done, (c == N) ? 1 : 0);
    end
    chk({tag, " busy@done"}, o_busy, 1);
    @(posedge i_clk_pix); #1;
    chk({tag, " busy end"}, o_busy, 0);
    chk({tag, " done end"}, o_done, 0);
    model_frame();
    check_all(tag);
  endtask

  task automatic reset_pulse();
    @(negedge i_clk_pix);
    i_rst_n = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    chk("reset busy", o_busy, 0);
    @(negedge i_clk_pix);
    i_rst_n = 1'b1;
    @(posedge i_clk_pix); #1;
  endtask

  initial begin
    int fall_exp[5];
    int yexp;
    fall_exp = '{0, 1, 3, 6, 10};
    model_reset();

    #12;
    check_all("por");
    chk("por busy", o_busy, 0);
    chk("por done", o_done, 0);
    i_rst_n = 1'b1;
    @(posedge i_clk_pix); #1;

    // Free fall onto floor 40 (ground 533).
    i_floor = 16'd40;
    for (int f = 0; f < 60; f++) begin
      run_frame("fall");
      if (f < 5)
        for (int k = 0; k < N; k++) chk("fall y", $signed(o_spry[k*CW +: CW]), fall_exp[f]);
    end
    chk("landed y0", $signed(o_spry[0 +: CW]), 533);
    chk("landed jumping", o_jumping, 0);

    // Walking on channel 1.
    i_run_speed = 8'd3;
    i_right = 4'b0010;
    run_frame("walk");
    chk("walk x1", $signed(o_sprx[CW +: CW]), 83);
    chk("walk flag", o_walking, 4'b0010);
    i_left = 4'b0010;
    run_frame("lr both");
    chk("lr x1", $signed(o_sprx[CW +: CW]), 83);
    chk("lr walk", o_walking[1], 0);
    i_right = '0;
    run_frame("left");
    i_right = 4'b0010;
    run_frame("lr face held");
    chk("face held", o_face_left[1], 1);
    i_left = '0;
    i_run_speed = 8'd50;
    for (int f = 0; f < 20; f++) run_frame("run edge");
    chk("right clamp", $signed(o_sprx[CW +: CW]), 781);
    i_right = '0;

    // Jump on channel 0 with velocity 10.
    i_jump_vel = 8'd10;
    i_jump = 4'b0001;
    run_frame("jump");
    chk("jump hold y", $signed(o_spry[0 +: CW]), 533);
    chk("jump air", o_jumping[0], 1);
    i_jump = '0;
    yexp = 533;
    for (int f = 0; f < 21; f++) begin
      run_frame("arc");
      yexp += f - 10;
      chk("arc y", $signed(o_spry[0 +: CW]), yexp);
    end
    chk("arc land", o_jumping[0], 0);

    // Overrun: second i_frame two cycles into the sweep.
    i_frame = 1'b1;
    @(posedge i_clk_pix); #1;
    i_frame = 1'b0;
    @(posedge i_clk_pix); #1;
    i_frame = 1'b1;
    @(posedge i_clk_pix); #1;
    i_frame = 1'b0;
    @(posedge i_clk_pix); #1;
    @(posedge i_clk_pix); #1;
    chk("ovr done", o_done, 1);
    @(posedge i_clk_pix); #1;
    chk("ovr idle", o_busy, 0);
    @(posedge i_clk_pix); #1;
    chk("ovr no restart", o_busy, 0);
    m_ovr = 1;
    model_frame();
    check_all("ovr");
    run_frame("ovr sticky");

    // Asynchronous reset three cycles into a sweep.
    i_right = 4'b1111;
    i_run_speed = 8'd5;
    i_frame = 1'b1;
    @(posedge i_clk_pix); #1;
    i_frame = 1'b0;
    @(posedge i_clk_pix); #1;
    @(posedge i_clk_pix); #1;
    #2;
    i_rst_n = 1'b0;
    #1;
    model_reset();
    check_all("midrst");
    chk("midrst busy", o_busy, 0);
    chk("midrst done", o_done, 0);
    i_right = '0;
    @(negedge i_clk_pix);
    i_rst_n = 1'b1;
    @(posedge i_clk_pix); #1;
    run_frame("post rst");

`ifdef SPRITE_MOTION_COLLIDE_EN
    reset_pulse();
    i_floor = '0;
    i_blk_left = 16'd300; i_blk_right = 16'd500; i_blk_height = 16'd100;
    for (int f = 0; f < 60; f++) run_frame("c fall");
    i_right = 4'b1000; i_run_speed = 8'd67;
    run_frame("c pos");
    chk("c x275", $signed(o_sprx[3*CW +: CW]), 275);
    i_run_speed = 8'd8;
    run_frame("c push");
    chk("c stop", $signed(o_sprx[3*CW +: CW]), 281);
    i_jump = 4'b1000; i_jump_vel = 8'd15;
    run_frame("c jump");
    i_jump = '0;
    for (int f = 0; f < 22; f++) run_frame("c arc");
    i_right = '0;
    run_frame("c top");
    chk("c land y", $signed(o_spry[3*CW +: CW]), 473);
    chk("c land air", o_jumping[3], 0);
`endif

    // Randomized frames against the model.
    reset_pulse();
    for (int f = 0; f < 150; f++) begin
      i_left      = N'($urandom);
      i_right     = N'($urandom);
      i_jump      = N'($urandom);
      i_run_speed = 8'($urandom_range(0, 20));
      i_jump_vel  = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) i_floor = 16'($urandom_range(0, 80));
      if ($urandom_range(0, 9) == 0) begin
        i_blk_left   = 16'($urandom_range(100, 400));
        i_blk_right  = i_blk_left + 16'($urandom_range(20, 200));
        i_blk_height = 16'($urandom_range(20, 150));
      end
      run_frame("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
